// File: rtl/vga_window_reader_if.sv
// Frame-buffer read port: the reader drives the address, the BRAM returns {R,G,B}
// data a fixed number of cycles later.
interface vga_window_reader_if #(
   parameter int COLOR_W = 4,
   parameter int ADDR_W  = 17
);
   logic [ADDR_W-1:0]    frame_addr;
   logic [3*COLOR_W-1:0] vga_in;

   modport master (output frame_addr, input vga_in);
   modport slave  (input frame_addr, output vga_in);
endinterface

// File: rtl/vga_window_reader.sv
// Programmable VGA timing generator that fetches a (optionally pixel-replicated) image
// window from a synchronous BRAM and delay-matches sync/DE/colour to the read latency.
module vga_window_reader #(
   parameter int COLOR_W    = 4,
   parameter int ADDR_W     = 17,
   parameter int CNT_W      = 10,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int HSYNC_POL  = 0,
   parameter int VSYNC_POL  = 0,
   parameter int WIN_X      = 160,
   parameter int WIN_Y      = 120,
   parameter int WIN_W      = 320,
   parameter int WIN_H      = 240,
   parameter int SCALE_LOG2 = 0,
   parameter int RD_LAT     = 1
) (
   input  logic                 clk25,
   input  logic                 rst_n,
   vga_window_reader_if.master  bram,
   input  logic [3*COLOR_W-1:0] border_color,
   output logic [COLOR_W-1:0]   vga_red,
   output logic [COLOR_W-1:0]   vga_green,
   output logic [COLOR_W-1:0]   vga_blue,
   output logic                 vga_hsync,
   output logic                 vga_vsync,
   output logic                 vga_de,
   output logic [CNT_W-1:0]     HCnt,
   output logic [CNT_W-1:0]     VCnt,
   output logic                 frame_start
);

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int LAT       = RD_LAT + 2;
   localparam int HS_START  = H_ACTIVE + H_FP;
   localparam int HS_END    = HS_START + H_SYNC;
   localparam int VS_START  = V_ACTIVE + V_FP;
   localparam int VS_END    = VS_START + V_SYNC;
   localparam int WIN_X_END = WIN_X + (WIN_W << SCALE_LOG2);
   localparam int WIN_Y_END = WIN_Y + (WIN_H << SCALE_LOG2);
   localparam int SUB_W     = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'((1 << SCALE_LOG2) - 1);
   localparam logic H_POL   = (HSYNC_POL != 0);
   localparam logic V_POL   = (VSYNC_POL != 0);

   logic [CNT_W-1:0]  h, v, h_next, v_next;
   logic              run;
   int                hi, vi;
   logic              h_wrap, v_wrap, active, win_row, in_win, hs_on, vs_on;
   logic [ADDR_W-1:0] line_base, col;
   logic [SUB_W-1:0]  x_sub, y_sub;
   logic [LAT-2:0]    act_p, win_p, hs_p, vs_p;

   assign HCnt = h;
   assign VCnt = v;

   always_comb begin
      hi      = int'(h);
      vi      = int'(v);
      h_wrap  = (hi == H_TOTAL - 1);
      v_wrap  = (vi == V_TOTAL - 1);
      active  = (hi < H_ACTIVE) && (vi < V_ACTIVE);
      win_row = (vi >= WIN_Y) && (vi < WIN_Y_END) && (vi < V_ACTIVE);
      in_win  = active && win_row && (hi >= WIN_X) && (hi < WIN_X_END);
      hs_on   = (hi >= HS_START) && (hi < HS_END);
      vs_on   = (vi >= VS_START) && (vi < VS_END);
   end

   // The first edge after reset only arms 'run', so (0,0) is shown for a full cycle.
   always_comb begin
      h_next = h;
      v_next = v;
      if (run) begin
         if (h_wrap) begin
            h_next = '0;
            v_next = v_wrap ? '0 : v + 1'b1;
         end else begin
            h_next = h + 1'b1;
         end
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         run         <= 1'b0;
         h           <= '0;
         v           <= '0;
         frame_start <= 1'b0;
      end else begin
         run         <= 1'b1;
         h           <= h_next;
         v           <= v_next;
         frame_start <= (h_next == '0) && (v_next == '0);
      end
   end

   // Incremental addressing: line_base steps by WIN_W once every 2^SCALE_LOG2 window
   // rows, col steps once every 2^SCALE_LOG2 window pixels and restarts each line.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         bram.frame_addr <= '0;
         line_base       <= '0;
         col             <= '0;
         x_sub           <= '0;
         y_sub           <= '0;
      end else if (run) begin
         if (in_win) begin
            bram.frame_addr <= line_base + col;
            if (x_sub == SUB_LAST) begin
               x_sub <= '0;
               col   <= col + 1'b1;
            end else begin
               x_sub <= x_sub + 1'b1;
            end
         end
         if (h_wrap) begin
            col   <= '0;
            x_sub <= '0;
            if (v_wrap) begin
               line_base <= '0;
               y_sub     <= '0;
            end else if (win_row) begin
               if (y_sub == SUB_LAST) begin
                  y_sub     <= '0;
                  line_base <= line_base + ADDR_W'(WIN_W);
               end else begin
                  y_sub <= y_sub + 1'b1;
               end
            end
         end
      end
   end

   // Flags ride LAT-1 stages, then the output registers meet the BRAM data.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         act_p                          <= '0;
         win_p                          <= '0;
         hs_p                           <= '0;
         vs_p                           <= '0;
         vga_de                         <= 1'b0;
         vga_hsync                      <= ~H_POL;
         vga_vsync                      <= ~V_POL;
         {vga_red, vga_green, vga_blue} <= '0;
      end else begin
         act_p     <= {act_p[LAT-3:0], run & active};
         win_p     <= {win_p[LAT-3:0], run & in_win};
         hs_p      <= {hs_p[LAT-3:0], run & hs_on};
         vs_p      <= {vs_p[LAT-3:0], run & vs_on};
         vga_de    <= act_p[LAT-2];
         vga_hsync <= hs_p[LAT-2] ? H_POL : ~H_POL;
         vga_vsync <= vs_p[LAT-2] ? V_POL : ~V_POL;
         if (!act_p[LAT-2]) begin
            {vga_red, vga_green, vga_blue} <= '0;
         end else if (!win_p[LAT-2]) begin
            {vga_red, vga_green, vga_blue} <= border_color;
         end else begin
            {vga_red, vga_green, vga_blue} <= bram.vga_in;
         end
      end
   end

endmodule

// File: tb/tb_vga_window_reader.sv
// Scoreboard bench for vga_window_reader: two reduced-timing instances, one plain
// window with RD_LAT=2, one 2x-replicated clipped window with inverted sync polarity.
module tb_vga_window_reader;

   localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6, HT = HA + HFP + HSY + HBP;
   localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3, VT = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;

   localparam int A_WX = 8, A_WY = 5, A_WW = 16, A_WH = 10, A_S = 0, A_RD = 2;
   localparam int A_LAT = A_RD + 2;
   localparam int B_WX = 0, B_WY = 0, B_WW = 24, B_WH = 20, B_S = 1, B_RD = 1;
   localparam int B_LAT = B_RD + 2;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [11:0] rgb;
   } pix_t;

   logic        clk25 = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] border_color = 12'hABC;

   logic [3:0] a_red, a_green, a_blue, b_red, b_green, b_blue;
   logic       a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
   logic [9:0] a_hcnt, a_vcnt, b_hcnt, b_vcnt;
   logic [11:0] a_rd1, a_rd2, b_rd1;

   int n_tests = 0;
   int n_fail  = 0;

   vga_window_reader_if #(.COLOR_W(4), .ADDR_W(17)) bus_a ();
   vga_window_reader_if #(.COLOR_W(4), .ADDR_W(17)) bus_b ();

   always #20 clk25 = ~clk25;

   always @(posedge clk25) begin
      a_rd1 <= bus_a.frame_addr[11:0];
      a_rd2 <= a_rd1;
      b_rd1 <= bus_b.frame_addr[11:0];
   end
   assign bus_a.vga_in = a_rd2;
   assign bus_b.vga_in = b_rd1;

   vga_window_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HSYNC_POL(0), .VSYNC_POL(0),
      .WIN_X(A_WX), .WIN_Y(A_WY), .WIN_W(A_WW), .WIN_H(A_WH),
      .SCALE_LOG2(A_S), .RD_LAT(A_RD)
   ) dut_a (
      .clk25(clk25), .rst_n(rst_n), .bram(bus_a), .border_color(border_color),
      .vga_red(a_red), .vga_green(a_green), .vga_blue(a_blue),
      .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_de(a_de),
      .HCnt(a_hcnt), .VCnt(a_vcnt), .frame_start(a_fs)
   );

   vga_window_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HSYNC_POL(1), .VSYNC_POL(1),
      .WIN_X(B_WX), .WIN_Y(B_WY), .WIN_W(B_WW), .WIN_H(B_WH),
      .SCALE_LOG2(B_S), .RD_LAT(B_RD)
   ) dut_b (
      .clk25(clk25), .rst_n(rst_n), .bram(bus_b), .border_color(border_color),
      .vga_red(b_red), .vga_green(b_green), .vga_blue(b_blue),
      .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_de(b_de),
      .HCnt(b_hcnt), .VCnt(b_vcnt), .frame_start(b_fs)
   );

   function automatic bit model_win(int h, int v, int wx, int wy, int ww, int wh, int s);
      return (h < HA) && (v < VA) && (h >= wx) && (h < wx + (ww << s)) &&
             (v >= wy) && (v < wy + (wh << s));
   endfunction

   function automatic int model_addr(int h, int v, int wx, int wy, int ww, int s);
      return ((((v - wy) >> s) * ww) + ((h - wx) >> s)) & 32'h1FFFF;
   endfunction

   function automatic pix_t model_pix(int h, int v, bit win, int addr, bit hp, bit vp);
      pix_t p;
      bit   hs_on, vs_on;
      hs_on = (h >= HA + HFP) && (h < HA + HFP + HSY);
      vs_on = (v >= VA + VFP) && (v < VA + VFP + VSY);
      p.de  = (h < HA) && (v < VA);
      p.hs  = hs_on ? hp : !hp;
      p.vs  = vs_on ? vp : !vp;
      p.rgb = !p.de ? 12'h000 : (win ? 12'(addr) : 12'hABC);
      return p;
   endfunction

   task automatic release_reset();
      @(negedge clk25);
      rst_n = 1'b0;
      repeat (3) @(negedge clk25);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk25);
      n_tests++;
      if ({a_hcnt, a_vcnt, a_fs} !== 21'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_a_counters got %h/%h/%b want 0/0/0", a_hcnt, a_vcnt, a_fs);
      end
      n_tests++;
      if (bus_a.frame_addr !== 17'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_a_addr got %h want 0", bus_a.frame_addr);
      end
      n_tests++;
      if ({a_de, a_hs, a_vs, a_red, a_green, a_blue} !== {3'b011, 12'h000}) begin
         n_fail++;
         $display("[TB] FAIL reset_a_outputs got %b%b%b %h%h%h want 011 000", a_de, a_hs, a_vs, a_red, a_green, a_blue);
      end
      n_tests++;
      if ({b_hcnt, b_vcnt, b_fs, bus_b.frame_addr} !== 38'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_b_state got %h/%h/%b/%h want 0", b_hcnt, b_vcnt, b_fs, bus_b.frame_addr);
      end
      n_tests++;
      if ({b_de, b_hs, b_vs, b_red, b_green, b_blue} !== {3'b000, 12'h000}) begin
         n_fail++;
         $display("[TB] FAIL reset_b_outputs got %b%b%b %h%h%h want 000 000", b_de, b_hs, b_vs, b_red, b_green, b_blue);
      end
   endtask

   task automatic test_frames_a(input int ncyc);
      pix_t q[$];
      pix_t e, got;
      int   h, v, ph, pv, exp_addr, spot, fs_cnt, de_cnt;
      bit   win;
      h = 0; v = 0; ph = -1; pv = -1; exp_addr = 0; fs_cnt = 0; de_cnt = 0;
      e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 12'h000};
      repeat (A_LAT) q.push_back(e);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk25);
         n_tests++;
         if (a_hcnt !== 10'(h) || a_vcnt !== 10'(v)) begin
            n_fail++;
            $display("[TB] FAIL a_counters got %0d,%0d want %0d,%0d", a_hcnt, a_vcnt, h, v);
         end
         n_tests++;
         if (a_fs !== ((h == 0) && (v == 0))) begin
            n_fail++;
            $display("[TB] FAIL a_frame_start at %0d,%0d got %b", h, v, a_fs);
         end
         n_tests++;
         if (bus_a.frame_addr !== 17'(exp_addr)) begin
            n_fail++;
            $display("[TB] FAIL a_addr after %0d,%0d got %0d want %0d", ph, pv, bus_a.frame_addr, exp_addr);
         end
         spot = -1;
         if (ph == 8 && pv == 5) spot = 0;
         else if (ph == 23 && pv == 5) spot = 15;
         else if (ph == 8 && pv == 6) spot = 16;
         else if (ph == 23 && pv == 14) spot = 159;
         if (spot >= 0) begin
            n_tests++;
            if (bus_a.frame_addr !== 17'(spot)) begin
               n_fail++;
               $display("[TB] FAIL a_spot_addr after %0d,%0d got %0d want %0d", ph, pv, bus_a.frame_addr, spot);
            end
         end
         win = model_win(h, v, A_WX, A_WY, A_WW, A_WH, A_S);
         if (win) exp_addr = model_addr(h, v, A_WX, A_WY, A_WW, A_S);
         q.push_back(model_pix(h, v, win, exp_addr, 1'b0, 1'b0));
         got = q.pop_front();
         n_tests++;
         if ({a_de, a_hs, a_vs, a_red, a_green, a_blue} !== got) begin
            n_fail++;
            $display("[TB] FAIL a_pixel cycle %0d got %b%b%b %h%h%h want %b%b%b %h", c, a_de, a_hs, a_vs, a_red, a_green, a_blue, got.de, got.hs, got.vs, got.rgb);
         end
         if (a_fs === 1'b1) fs_cnt++;
         if (a_de === 1'b1) de_cnt++;
         ph = h; pv = v;
         if (h == HT - 1) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
         end else begin
            h++;
         end
      end
      if (ncyc % FRAME == 0) begin
         n_tests++;
         if (fs_cnt != ncyc / FRAME) begin
            n_fail++;
            $display("[TB] FAIL a_frame_count got %0d want %0d", fs_cnt, ncyc / FRAME);
         end
         n_tests++;
         if (de_cnt != (ncyc / FRAME) * HA * VA) begin
            n_fail++;
            $display("[TB] FAIL a_de_count got %0d want %0d", de_cnt, (ncyc / FRAME) * HA * VA);
         end
      end
   endtask

   task automatic test_frames_b(input int ncyc);
      pix_t q[$];
      pix_t e, got;
      int   h, v, ph, pv, exp_addr, spot, fs_cnt, de_cnt;
      bit   win;
      h = 0; v = 0; ph = -1; pv = -1; exp_addr = 0; fs_cnt = 0; de_cnt = 0;
      e = '{de: 1'b0, hs: 1'b0, vs: 1'b0, rgb: 12'h000};
      repeat (B_LAT) q.push_back(e);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk25);
         n_tests++;
         if (b_hcnt !== 10'(h) || b_vcnt !== 10'(v)) begin
            n_fail++;
            $display("[TB] FAIL b_counters got %0d,%0d want %0d,%0d", b_hcnt, b_vcnt, h, v);
         end
         n_tests++;
         if (b_fs !== ((h == 0) && (v == 0))) begin
            n_fail++;
            $display("[TB] FAIL b_frame_start at %0d,%0d got %b", h, v, b_fs);
         end
         n_tests++;
         if (bus_b.frame_addr !== 17'(exp_addr)) begin
            n_fail++;
            $display("[TB] FAIL b_addr after %0d,%0d got %0d want %0d", ph, pv, bus_b.frame_addr, exp_addr);
         end
         spot = -1;
         if (ph == 1 && pv == 0) spot = 0;
         else if (ph == 2 && pv == 0) spot = 1;
         else if (ph == 3 && pv == 0) spot = 1;
         else if (ph == 3 && pv == 1) spot = 1;
         else if (ph == 0 && pv == 2) spot = 24;
         else if (ph == 39 && pv == 29) spot = 355;
         if (spot >= 0) begin
            n_tests++;
            if (bus_b.frame_addr !== 17'(spot)) begin
               n_fail++;
               $display("[TB] FAIL b_spot_addr after %0d,%0d got %0d want %0d", ph, pv, bus_b.frame_addr, spot);
            end
         end
         win = model_win(h, v, B_WX, B_WY, B_WW, B_WH, B_S);
         if (win) exp_addr = model_addr(h, v, B_WX, B_WY, B_WW, B_S);
         q.push_back(model_pix(h, v, win, exp_addr, 1'b1, 1'b1));
         got = q.pop_front();
         n_tests++;
         if ({b_de, b_hs, b_vs, b_red, b_green, b_blue} !== got) begin
            n_fail++;
            $display("[TB] FAIL b_pixel cycle %0d got %b%b%b %h%h%h want %b%b%b %h", c, b_de, b_hs, b_vs, b_red, b_green, b_blue, got.de, got.hs, got.vs, got.rgb);
         end
         if (b_fs === 1'b1) fs_cnt++;
         if (b_de === 1'b1) de_cnt++;
         ph = h; pv = v;
         if (h == HT - 1) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
         end else begin
            h++;
         end
      end
      if (ncyc % FRAME == 0) begin
         n_tests++;
         if (fs_cnt != ncyc / FRAME) begin
            n_fail++;
            $display("[TB] FAIL b_frame_count got %0d want %0d", fs_cnt, ncyc / FRAME);
         end
         n_tests++;
         if (de_cnt != (ncyc / FRAME) * HA * VA) begin
            n_fail++;
            $display("[TB] FAIL b_de_count got %0d want %0d", de_cnt, (ncyc / FRAME) * HA * VA);
         end
      end
   endtask

   task automatic test_midframe_reset();
      test_frames_a(20 * HT + 30);
      @(posedge clk25);
      #3;
      n_tests++;
      if (a_hcnt !== 10'd30 || a_vcnt !== 10'd20) begin
         n_fail++;
         $display("[TB] FAIL mid_position got %0d,%0d want 30,20", a_hcnt, a_vcnt);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({a_hcnt, a_vcnt, a_fs, bus_a.frame_addr} !== 38'd0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_a_state got %h/%h/%b/%h want 0", a_hcnt, a_vcnt, a_fs, bus_a.frame_addr);
      end
      n_tests++;
      if ({a_de, a_hs, a_vs, a_red, a_green, a_blue} !== {3'b011, 12'h000}) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_a_outputs got %b%b%b %h%h%h want 011 000", a_de, a_hs, a_vs, a_red, a_green, a_blue);
      end
      n_tests++;
      if ({b_hcnt, b_vcnt, b_fs, bus_b.frame_addr} !== 38'd0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_b_state got %h/%h/%b/%h want 0", b_hcnt, b_vcnt, b_fs, bus_b.frame_addr);
      end
      n_tests++;
      if ({b_de, b_hs, b_vs, b_red, b_green, b_blue} !== {3'b000, 12'h000}) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_b_outputs got %b%b%b %h%h%h want 000 000", b_de, b_hs, b_vs, b_red, b_green, b_blue);
      end
      repeat (2) @(negedge clk25);
      rst_n = 1'b1;
      test_frames_a(2 * FRAME);
   endtask

   initial begin
      test_reset();
      release_reset();
      test_frames_a(2 * FRAME);
      release_reset();
      test_frames_b(2 * FRAME);
      release_reset();
      test_midframe_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
